shift_add_multiplier: RTL and testbench

- Sequential unsigned shift-and-add multiplier.
- Sits directly downstream of the 8-bit bidirectional barrel shifter in the datapath and consumes its shifted operands.
- Each RUN cycle it adds the multiplicand to the accumulator when the current multiplier bit is 1, then shifts the multiplicand left by 1 and the multiplier right by 1.
- Start/ready/done handshake; the result is held until the next accepted start.

---
 rtl/shift_add_multiplier.sv | 102 ++++++++++
 tb/tb_shift_add_multiplier.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier with start/ready/done handshake.
// One partial product per clock; fixed latency of WIDTH cycles from accept to done.
module shift_add_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_reg, state_next;
  logic [2*WIDTH-1:0]   mcand_reg;
  logic [WIDTH-1:0]     mplier_reg;
  logic [2*WIDTH-1:0]   acc_reg;
  logic [CW-1:0]        count_reg;
  logic [2*WIDTH-1:0]   product_reg;

  logic [2*WIDTH-1:0]   addend;
  logic [2*WIDTH-1:0]   acc_sum;
  logic                 last_iter;

  // Gate the shifted multiplicand by the current multiplier LSB.
  genvar gi;
  generate
    for (gi = 0; gi < 2*WIDTH; gi++) begin : g_addend
      assign addend[gi] = mcand_reg[gi] & mplier_reg[0];
    end
  endgenerate

  assign acc_sum   = acc_reg + addend;
  assign last_iter = (count_reg == LAST_COUNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_iter) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_reg   <= '0;
      mplier_reg  <= '0;
      acc_reg     <= '0;
      count_reg   <= '0;
      product_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            mcand_reg  <= {{WIDTH{1'b0}}, a};
            mplier_reg <= b;
            acc_reg    <= '0;
            count_reg  <= '0;
          end
        end
        RUN: begin
          acc_reg    <= acc_sum;
          mcand_reg  <= mcand_reg << 1;
          mplier_reg <= mplier_reg >> 1;
          count_reg  <= count_reg + 1'b1;
          // Capture includes this edge's add so the final bit is not lost.
          if (last_iter) product_reg <= acc_sum;
        end
        default: begin
        end
      endcase
    end
  end

  assign ready   = (state_reg == IDLE);
  assign busy    = (state_reg == RUN);
  assign done    = (state_reg == DONE);
  assign product = product_reg;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed, table-driven bench for shift_add_multiplier (WIDTH=8) with
// hand-written sequences for busy-start and mid-operation reset.
module tb_shift_add_multiplier;

  localparam int WIDTH = 8;

  logic                 clk;
  logic                 rst;
  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 ready;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  int n_checks = 0;
  int n_fail   = 0;
  logic [2*WIDTH-1:0] last_product = '0;

  typedef struct {
    int a;
    int b;
    int expected;
  } vec_t;

  vec_t vecs [10];

  shift_add_multiplier #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Accepts one operation and checks handshake timing and the result.
  task automatic run_op(input int av, input int bv, input int expected);
    int w;
    int k;
    bit busy_ok;
    w = 0;
    while (ready !== 1'b1 && w < 30) begin
      @(posedge clk); #1;
      w++;
    end
    check("ready_before_start", {31'd0, ready}, 32'd1);
    a = WIDTH'(av);
    b = WIDTH'(bv);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = '0;
    b = '0;
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    check("product_held_in_run", {16'd0, product}, {16'd0, last_product});
    busy_ok = 1'b1;
    for (k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) break;
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
    check("busy_throughout_run", {31'd0, busy_ok}, 32'd1);
    check("done_latency", 32'(k), 32'd8);
    check("product", {16'd0, product}, 32'(expected));
    last_product = 16'(expected);
    $display("op a=%0d b=%0d -> product=%0d (expected %0d) done after %0d cycles",
             av, bv, product, expected, k);
    @(posedge clk); #1;
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("ready_after_done", {31'd0, ready}, 32'd1);
  endtask

  initial begin
    int ndone;
    int done_k;
    bit no_done;
    bit ready_ok;

    vecs[0] = '{a: 3,   b: 5,   expected: 15};
    vecs[1] = '{a: 243, b: 151, expected: 36693};
    vecs[2] = '{a: 255, b: 255, expected: 65025};
    vecs[3] = '{a: 0,   b: 200, expected: 0};
    vecs[4] = '{a: 200, b: 0,   expected: 0};
    vecs[5] = '{a: 1,   b: 1,   expected: 1};
    vecs[6] = '{a: 255, b: 1,   expected: 255};
    vecs[7] = '{a: 1,   b: 255, expected: 255};
    vecs[8] = '{a: 170, b: 85,  expected: 14450};
    vecs[9] = '{a: 16,  b: 16,  expected: 256};

    rst = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;

    // Asynchronous reset, checked before the first clock edge.
    #3 rst = 1'b1;
    #1;
    check("reset_ready", {31'd0, ready}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_product", {16'd0, product}, 32'd0);
    $display("reset: ready=%0b busy=%0b done=%0b product=%0d", ready, busy, done, product);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].expected);
    end

    // Product holds through idle cycles.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
    end
    check("product_hold_idle", {16'd0, product}, 32'd256);
    $display("hold: product=%0d after 5 idle cycles", product);

    // Start pulses while busy/done must be ignored.
    a = 8'd7;
    b = 8'd9;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0;
    done_k = 0;
    for (int k = 1; k <= 14; k++) begin
      start = (k == 3 || k == 8 || k == 9);
      a = 8'd100;
      b = 8'd100;
      @(posedge clk); #1;
      start = 1'b0;
      if (done === 1'b1) begin
        ndone++;
        done_k = k;
      end
    end
    check("busy_start_done_count", 32'(ndone), 32'd1);
    check("busy_start_done_cycle", 32'(done_k), 32'd8);
    check("busy_start_product", {16'd0, product}, 32'd63);
    check("busy_start_not_queued", {31'd0, busy}, 32'd0);
    $display("busy-start: product=%0d done pulses=%0d at cycle %0d", product, ndone, done_k);
    last_product = 16'd63;

    // Reset mid-operation aborts and clears the product.
    a = 8'd12;
    b = 8'd12;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
    end
    check("midop_busy_before_rst", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("midop_rst_ready", {31'd0, ready}, 32'd1);
    check("midop_rst_busy", {31'd0, busy}, 32'd0);
    check("midop_rst_product", {16'd0, product}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    no_done = 1'b1;
    ready_ok = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done !== 1'b0) no_done = 1'b0;
      if (ready !== 1'b1) ready_ok = 1'b0;
    end
    check("midop_no_done", {31'd0, no_done}, 32'd1);
    check("midop_stays_idle", {31'd0, ready_ok}, 32'd1);
    $display("midop-reset: product=%0d no_done=%0b", product, no_done);
    last_product = '0;
    run_op(12, 12, 144);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no end of test, expected completion");
    $fatal(1, "timeout");
  end

endmodule
